// File: rtl/debug_pager.sv
// Debug word viewer: snapshots a 32-bit debug word, pages through its bytes with a
// debounced button, and flags changes of the displayed byte with a timed indicator.
module debug_pager #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned BLINK_CYCLES    = 12500000
) (
   input  logic        clk50M,
   input  logic        rst,
   input  logic [31:0] debug_in,
   input  logic        btn_next,
   input  logic        freeze,
   output logic [3:0]  nib_hi,
   output logic [3:0]  nib_lo,
   output logic [1:0]  page,
   output logic        changed,
   output logic [7:0]  led_byte
);

   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int BL_W = $clog2(BLINK_CYCLES + 1);

   logic            sync1, sync2;
   logic            stable, stable_d;
   logic [DB_W-1:0] db_cnt;
   logic [31:0]     snapshot;
   logic [7:0]      prev;
   logic [7:0]      sel;
   logic            page_moved;
   logic [BL_W-1:0] blink_cnt;
   logic            rise;
   logic            trigger;

   always_comb begin
      sel = 8'h00;
      case (page)
         2'd0: sel = snapshot[7:0];
         2'd1: sel = snapshot[15:8];
         2'd2: sel = snapshot[23:16];
         2'd3: sel = snapshot[31:24];
         default: sel = 8'h00;
      endcase
   end

   assign rise = stable & ~stable_d;
   // page_moved marks the first cycle showing a new page, so the byte swap is not
   // mistaken for a data change.
   assign trigger = (sel != prev) && !page_moved;

   // Button path: synchronizer, debouncer, edge detect.
   always_ff @(posedge clk50M) begin
      if (rst) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         stable   <= 1'b0;
         stable_d <= 1'b0;
         db_cnt   <= '0;
      end else begin
         sync1    <= btn_next;
         sync2    <= sync1;
         stable_d <= stable;
         if (sync2 == stable) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            stable <= sync2;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk50M) begin
      if (rst) begin
         page       <= 2'd0;
         page_moved <= 1'b0;
         snapshot   <= 32'h0;
         prev       <= 8'h00;
         nib_hi     <= 4'h0;
         nib_lo     <= 4'h0;
         blink_cnt  <= '0;
         changed    <= 1'b0;
         led_byte   <= 8'b0000_0001;
      end else begin
         if (rise) page <= page + 2'd1;
         page_moved <= rise;
         if (!freeze) snapshot <= debug_in;
         prev   <= sel;
         nib_hi <= sel[7:4];
         nib_lo <= sel[3:0];
         if (trigger) begin
            blink_cnt <= BL_W'(BLINK_CYCLES);
         end else if (blink_cnt != '0) begin
            blink_cnt <= blink_cnt - 1'b1;
         end
         changed  <= (blink_cnt != '0);
         led_byte <= {2'b00, stable, freeze, 4'b0001 << page};
      end
   end

endmodule
